// File: rtl/text_line_streamer.sv
// Streams the characters of one text line: looks up the line descriptor, then unpacks ROM words MSB-first.
// Optional build macro TEXT_LINE_STREAMER_EOL_EN appends a 0x0A end-of-line beat after each line.
module text_line_streamer #(
    parameter int CHAR_W         = 8,
    parameter int CHARS_PER_WORD = 2,
    parameter int ADDR_W         = 8,
    parameter int LINE_W         = 8,
    parameter int LEN_W          = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [LINE_W-1:0]                line_in,
    output logic                             busy,
    output logic [LINE_W-1:0]                map_line,
    input  logic [LEN_W+ADDR_W-1:0]          map_desc,
    output logic [ADDR_W-1:0]                rom_addr,
    input  logic [CHAR_W*CHARS_PER_WORD-1:0] rom_data,
    output logic [CHAR_W-1:0]                out_char,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             out_last,
    output logic                             done
);

    localparam int IDX_W = (CHARS_PER_WORD > 1) ? $clog2(CHARS_PER_WORD) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CHARS_PER_WORD - 1);

`ifdef TEXT_LINE_STREAMER_EOL_EN
    typedef enum logic [2:0] {
        S_IDLE, S_MAP_REQ, S_MAP_CAP, S_FETCH_REQ, S_FETCH_CAP, S_EMIT, S_EOL, S_DONE
    } state_t;
    localparam state_t END_ST = S_EOL;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_MAP_REQ, S_MAP_CAP, S_FETCH_REQ, S_FETCH_CAP, S_EMIT, S_DONE
    } state_t;
    localparam state_t END_ST = S_DONE;
`endif

    state_t                             state_q, state_d;
    logic [LINE_W-1:0]                  map_line_q, map_line_d;
    logic [ADDR_W-1:0]                  ptr_q, ptr_d;
    logic [LEN_W-1:0]                   rem_q, rem_d;
    logic [CHAR_W*CHARS_PER_WORD-1:0]   buf_q, buf_d;
    logic [IDX_W-1:0]                   idx_q, idx_d;
    logic [CHAR_W-1:0]                  word_chars [CHARS_PER_WORD];

    // Slot 0 is the most-significant character of the buffered word.
    genvar gi;
    generate
        for (gi = 0; gi < CHARS_PER_WORD; gi++) begin : g_slice
            assign word_chars[gi] = buf_q[(CHARS_PER_WORD-1-gi)*CHAR_W +: CHAR_W];
        end
    endgenerate

    assign map_line = map_line_q;
    assign rom_addr = ptr_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            map_line_q <= '0;
            ptr_q      <= '0;
            rem_q      <= '0;
            buf_q      <= '0;
            idx_q      <= '0;
        end else begin
            state_q    <= state_d;
            map_line_q <= map_line_d;
            ptr_q      <= ptr_d;
            rem_q      <= rem_d;
            buf_q      <= buf_d;
            idx_q      <= idx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        map_line_d = map_line_q;
        ptr_d      = ptr_q;
        rem_d      = rem_q;
        buf_d      = buf_q;
        idx_d      = idx_q;
        busy       = 1'b0;
        out_valid  = 1'b0;
        out_char   = '0;
        out_last   = 1'b0;
        done       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    map_line_d = line_in;
                    state_d    = S_MAP_REQ;
                end
            end
            S_MAP_REQ: begin
                busy    = 1'b1;
                state_d = S_MAP_CAP;
            end
            S_MAP_CAP: begin
                busy    = 1'b1;
                ptr_d   = map_desc[ADDR_W-1:0];
                rem_d   = map_desc[LEN_W+ADDR_W-1:ADDR_W];
                state_d = (map_desc[LEN_W+ADDR_W-1:ADDR_W] == '0) ? END_ST : S_FETCH_REQ;
            end
            S_FETCH_REQ: begin
                busy    = 1'b1;
                state_d = S_FETCH_CAP;
            end
            S_FETCH_CAP: begin
                busy    = 1'b1;
                buf_d   = rom_data;
                idx_d   = '0;
                state_d = S_EMIT;
            end
            S_EMIT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_char  = word_chars[idx_q];
`ifndef TEXT_LINE_STREAMER_EOL_EN
                out_last  = (idx_q == IDX_LAST) && (rem_q == LEN_W'(1));
`endif
                if (out_ready) begin
                    if (idx_q != IDX_LAST) begin
                        idx_d = idx_q + IDX_W'(1);
                    end else begin
                        // Pointer wraps naturally at the top of the ROM.
                        rem_d   = rem_q - LEN_W'(1);
                        ptr_d   = ptr_q + ADDR_W'(1);
                        state_d = (rem_q > LEN_W'(1)) ? S_FETCH_REQ : END_ST;
                    end
                end
            end
`ifdef TEXT_LINE_STREAMER_EOL_EN
            S_EOL: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_char  = CHAR_W'(8'h0A);
                out_last  = 1'b1;
                if (out_ready) state_d = S_DONE;
            end
`endif
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_text_line_streamer.sv
// Table-driven bench for text_line_streamer with behavioural line-mapper and character ROM models.
// Honours TEXT_LINE_STREAMER_EOL_EN when the design is built with it.
module tb_text_line_streamer;

`ifdef TEXT_LINE_STREAMER_EOL_EN
    localparam bit EOL_EN = 1'b1;
`else
    localparam bit EOL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  line_in = '0;
    logic        busy;
    logic [7:0]  map_line;
    logic [15:0] map_desc = '0;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data = '0;
    logic [7:0]  out_char;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_last;
    logic        done;

    text_line_streamer dut (
        .clk(clk), .rst(rst), .start(start), .line_in(line_in), .busy(busy),
        .map_line(map_line), .map_desc(map_desc), .rom_addr(rom_addr), .rom_data(rom_data),
        .out_char(out_char), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .done(done)
    );

    always #5 clk = ~clk;

    logic [15:0] map_tab [256];
    logic [15:0] rom     [256];
    logic [7:0]  data_addr = '0;
    logic [7:0]  cap_addr  = '0;

    always @(posedge clk) begin
        map_desc  <= map_tab[map_line];
        rom_data  <= rom[rom_addr];
        data_addr <= rom_addr;
        cap_addr  <= data_addr;
    end

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int start_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] ch_q[$];
    logic       last_q[$];
    logic [7:0] addr_q[$];
    int  done_cnt, first_valid, done_cyc, stall_err;
    bit  prev_valid = 1'b0, prev_stall = 1'b0;
    logic [7:0] prev_char = '0;

    always @(negedge clk) begin
        if (out_valid && !prev_valid && !(EOL_EN && out_last)) addr_q.push_back(cap_addr);
        if (prev_stall && (!out_valid || out_char != prev_char)) stall_err++;
        if (out_valid && out_ready) begin
            ch_q.push_back(out_char);
            last_q.push_back(out_last);
        end
        if (out_valid && first_valid < 0) first_valid = cyc - start_cyc;
        if (done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc - start_cyc;
        end
        prev_valid = out_valid;
        prev_stall = out_valid && !out_ready;
        prev_char  = out_char;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("[TB] ok %s = %0h", name, act);
        end
    endtask

    typedef struct {
        logic [7:0]  line;
        bit          rnd;
        int          n;
        logic [95:0] chars;
        int          na;
        logic [47:0] addrs;
    } vec_t;

    vec_t vecs [6];

    task automatic run_line(input logic [7:0] line, input bit rnd, input int inject);
        ch_q.delete(); last_q.delete(); addr_q.delete();
        done_cnt = 0; first_valid = -1; done_cyc = -1; stall_err = 0;
        @(posedge clk); #1;
        start = 1'b1; line_in = line;
        out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        @(posedge clk); #1;
        start = 1'b0; start_cyc = cyc;
        for (int k = 0; k < 400 && done_cnt == 0; k++) begin
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            if (k == inject) begin start = 1'b1; line_in = 8'd3; end
            else start = 1'b0;
            @(posedge clk); #1;
        end
        start = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        if (done_cnt == 0) check("done_timeout", 0, 1);
    endtask

    task automatic verify(input int v, input string tag);
        int total;
        logic [7:0] exp_c;
        total = vecs[v].n + (EOL_EN ? 1 : 0);
        check({tag, "_beats"}, ch_q.size(), total);
        for (int i = 0; i < total && i < ch_q.size(); i++) begin
            exp_c = (i < vecs[v].n) ? vecs[v].chars[95 - 8*i -: 8] : 8'h0A;
            check($sformatf("%s_char%0d", tag, i), ch_q[i], exp_c);
            check($sformatf("%s_last%0d", tag, i), last_q[i], (i == total - 1));
        end
        check({tag, "_nwords"}, addr_q.size(), vecs[v].na);
        for (int i = 0; i < vecs[v].na && i < addr_q.size(); i++)
            check($sformatf("%s_addr%0d", tag, i), addr_q[i], vecs[v].addrs[47 - 8*i -: 8]);
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_stall"}, stall_err, 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin map_tab[i] = '0; rom[i] = '0; end
        map_tab[1] = 16'h0300; map_tab[2] = 16'h0503; map_tab[3] = 16'h02FF;
        map_tab[4] = 16'h0010; map_tab[5] = 16'h0300; map_tab[6] = 16'h0102;
        rom[0] = 16'h3131; rom[1] = 16'h6172; rom[2] = 16'h7320;
        rom[3] = 16'h4142; rom[4] = 16'h4344; rom[5] = 16'h4546;
        rom[6] = 16'h4748; rom[7] = 16'h494A; rom[255] = 16'h5859;

        vecs[0] = '{8'd1, 1'b0, 6,  96'h313161727320_000000000000, 3, 48'h000102_000000};
        vecs[1] = '{8'd2, 1'b0, 10, 96'h4142434445464748494A_0000, 5, 48'h0304050607_00};
        vecs[2] = '{8'd3, 1'b0, 4,  96'h58593131_0000000000000000, 2, 48'hFF00_00000000};
        vecs[3] = '{8'd4, 1'b0, 0,  96'h0, 0, 48'h0};
        vecs[4] = '{8'd5, 1'b1, 6,  96'h313161727320_000000000000, 3, 48'h000102_000000};
        vecs[5] = '{8'd6, 1'b1, 2,  96'h7320_00000000000000000000, 1, 48'h02_0000000000};

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_valid", out_valid, 0);
        check("rst_outs", {out_last, done, map_line, rom_addr, out_char}, 0);
        rst = 1'b1;

        for (int v = 0; v < 6; v++) begin
            run_line(vecs[v].line, vecs[v].rnd, -1);
            verify(v, $sformatf("v%0d", v));
            if (v == 0) check("v0_first_valid", first_valid, 4);
            if (v == 3 && !EOL_EN) begin
                check("v3_done_cyc", done_cyc, 2);
                check("v3_no_valid", first_valid, -1);
            end
        end

        // Reset while the third character is being presented.
        @(posedge clk); #1;
        start = 1'b1; line_in = 8'd2; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        begin
            int k;
            for (k = 0; k < 100; k++) begin
                @(posedge clk); #1;
                if (ch_q.size() >= 2 && out_valid && busy) break;
            end
            if (k == 100) check("reset_wait", 0, 1);
        end
        check("pre_rst_busy", busy, 1);
        rst = 1'b0; start = 1'b1; line_in = 8'd3;
        @(posedge clk); #1;
        check("midrst_busy", busy, 0);
        check("midrst_valid", out_valid, 0);
        check("midrst_outs", {out_last, done, map_line, rom_addr, out_char}, 0);
        start = 1'b0; rst = 1'b1;

        run_line(8'd2, 1'b0, -1);
        verify(1, "after_rst");

        // A second start while busy must not disturb the line in flight.
        run_line(8'd1, 1'b0, 3);
        check("ignored_start_map_line", map_line, 8'd1);
        verify(0, "ignored_start");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
